// File: rtl/motor_cmd_sequencer.sv
// rtl/motor_cmd_sequencer.sv - H-bridge command sequencer with PWM ramp, dead time and watchdog
module motor_cmd_sequencer #(
    parameter int RAMP_DIV        = 4,
    parameter int RAMP_STEP       = 256,
    parameter int DEADTIME_CYCLES = 8,
    parameter int WDOG_CYCLES     = 1000000
) (
    input  logic        user_clk,
    input  logic        rst_n,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_in,
    input  logic [15:0] pwm_in,
    output logic [7:0]  cmd_out,
    output logic [15:0] pwm_out,
    output logic        busy,
    output logic        wdog_trip,
    output logic        bad_cmd
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BRAKE = 2'd2;
    localparam logic [1:0] ST_DEAD  = 2'd3;

    localparam logic [7:0] CMD_STOP = 8'd0;
    localparam logic [7:0] CMD_MAX  = 8'd4;

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = $clog2(DEADTIME_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEADTIME_CYCLES);
    localparam logic [DW-1:0] DEAD_ONE   = DW'(1);
    localparam logic [31:0]   WDOG_LOAD  = 32'(WDOG_CYCLES);
    localparam logic [16:0]   STEP17     = 17'(RAMP_STEP);

    logic [1:0]    state;
    logic [7:0]    tgt_cmd;
    logic [15:0]   tgt_pwm;
    logic [PW-1:0] presc;
    logic          tick;
    logic [DW-1:0] dead_cnt;
    logic [31:0]   wdog_cnt;
    logic          wdog_expire;
    logic          cmd_valid;

    logic [16:0]   goal;
    logic [16:0]   cur;
    logic [16:0]   diff;
    logic [16:0]   ramp_up;
    logic [16:0]   ramp_dn;
    logic          up;
    logic [15:0]   pwm_step;

    assign tick      = (presc == PRESC_LAST);
    assign cmd_valid = (cmd_in <= CMD_MAX);

    // A write landing on the expiry cycle takes priority, so expiry needs a quiet cycle
    assign wdog_expire = (WDOG_CYCLES != 0) && !cmd_wr && (wdog_cnt == 32'd1);

    assign busy = (state == ST_BRAKE) || (state == ST_DEAD) ||
                  ((state == ST_RUN) && (pwm_out != tgt_pwm));

    // Free-running ramp prescaler, one tick every RAMP_DIV cycles
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Watchdog counter: reloaded by every write, otherwise counts down and sticks at 0
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (cmd_wr) begin
            wdog_cnt <= WDOG_LOAD;
        end else if (wdog_cnt != 32'd0) begin
            wdog_cnt <= wdog_cnt - 32'd1;
        end
    end

    // Target registers and sticky flags; a bad command or watchdog expiry parks the target at STOP/0
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_cmd   <= CMD_STOP;
            tgt_pwm   <= '0;
            bad_cmd   <= 1'b0;
            wdog_trip <= 1'b0;
        end else if (cmd_wr) begin
            wdog_trip <= 1'b0;
            if (cmd_valid) begin
                tgt_cmd <= cmd_in;
                tgt_pwm <= (cmd_in == CMD_STOP) ? 16'd0 : pwm_in;
                bad_cmd <= 1'b0;
            end else begin
                tgt_cmd <= CMD_STOP;
                tgt_pwm <= '0;
                bad_cmd <= 1'b1;
            end
        end else if (wdog_expire) begin
            tgt_cmd   <= CMD_STOP;
            tgt_pwm   <= '0;
            wdog_trip <= 1'b1;
        end
    end

    // Ramp goal and next PWM value, computed in 17 bits so the step never wraps past the goal
    always_comb begin
        goal     = '0;
        cur      = {1'b0, pwm_out};
        diff     = '0;
        up       = 1'b0;
        ramp_up  = cur + STEP17;
        ramp_dn  = cur - STEP17;
        pwm_step = pwm_out;
        if ((state == ST_RUN) && (tgt_cmd == cmd_out)) begin
            goal = {1'b0, tgt_pwm};
        end
        if (goal >= cur) begin
            diff = goal - cur;
            up   = 1'b1;
        end else begin
            diff = cur - goal;
        end
        if (diff <= STEP17) begin
            pwm_step = goal[15:0];
        end else if (up) begin
            pwm_step = ramp_up[15:0];
        end else begin
            pwm_step = ramp_dn[15:0];
        end
    end

    // PWM output only moves on a prescaler tick
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else if (tick) begin
            pwm_out <= pwm_step;
        end
    end

    // Direction sequencer: a direction change always brakes to 0 and waits out the dead time
    always_ff @(posedge user_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cmd_out  <= CMD_STOP;
            dead_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tgt_cmd != CMD_STOP) begin
                        state   <= ST_RUN;
                        cmd_out <= tgt_cmd;
                    end
                end
                ST_RUN: begin
                    if (tgt_cmd != cmd_out) begin
                        state <= ST_BRAKE;
                    end
                end
                ST_BRAKE: begin
                    if (pwm_out == 16'd0) begin
                        state    <= ST_DEAD;
                        cmd_out  <= CMD_STOP;
                        dead_cnt <= DEAD_LOAD;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt <= DEAD_ONE) begin
                        dead_cnt <= '0;
                        if (tgt_cmd == CMD_STOP) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_RUN;
                            cmd_out <= tgt_cmd;
                        end
                    end else begin
                        dead_cnt <= dead_cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cmd_out <= CMD_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// tb/tb_motor_cmd_sequencer.sv - self-checking bench for motor_cmd_sequencer
module tb_motor_cmd_sequencer;

    localparam int RAMP_DIV  = 4;
    localparam int RAMP_STEP = 256;
    localparam int DEADTIME  = 8;
    localparam int WDOG      = 1000;

    logic        user_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        cmd_wr   = 1'b0;
    logic [7:0]  cmd_in   = 8'd0;
    logic [15:0] pwm_in   = 16'd0;
    logic [7:0]  cmd_out;
    logic [15:0] pwm_out;
    logic        busy;
    logic        wdog_trip;
    logic        bad_cmd;
    logic [26:0] act_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 user_clk = ~user_clk;

    assign act_vec = {cmd_out, pwm_out, busy, wdog_trip, bad_cmd};

    motor_cmd_sequencer #(
        .RAMP_DIV(RAMP_DIV),
        .RAMP_STEP(RAMP_STEP),
        .DEADTIME_CYCLES(DEADTIME),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .user_clk(user_clk),
        .rst_n(rst_n),
        .cmd_wr(cmd_wr),
        .cmd_in(cmd_in),
        .pwm_in(pwm_in),
        .cmd_out(cmd_out),
        .pwm_out(pwm_out),
        .busy(busy),
        .wdog_trip(wdog_trip),
        .bad_cmd(bad_cmd)
    );

    // Reference model: motor phase, targets and timers kept as plain integers
    typedef enum int {P_IDLE, P_RUN, P_BRAKE, P_DEAD} phase_t;
    phase_t m_ph;
    int m_cmd, m_pwm, m_tcmd, m_tpwm, m_dead, m_wd, m_edges;
    bit m_trip, m_bad;

    function automatic void model_reset();
        m_ph = P_IDLE; m_cmd = 0; m_pwm = 0; m_tcmd = 0; m_tpwm = 0;
        m_dead = 0; m_wd = 0; m_edges = 0; m_trip = 0; m_bad = 0;
    endfunction

    function automatic bit model_busy();
        return (m_ph == P_BRAKE) || (m_ph == P_DEAD) || (m_ph == P_RUN && m_pwm != m_tpwm);
    endfunction

    function automatic logic [26:0] exp_vec();
        return {8'(m_cmd), 16'(m_pwm), model_busy(), m_trip, m_bad};
    endfunction

    function automatic void model_edge(input bit wr, input int c, input int p);
        bit tick;
        int goal, d, new_pwm;
        tick = (m_edges % RAMP_DIV) == (RAMP_DIV - 1);
        m_edges++;
        goal = (m_ph == P_RUN && m_tcmd == m_cmd) ? m_tpwm : 0;
        new_pwm = m_pwm;
        if (tick) begin
            d = goal - m_pwm;
            if (d > RAMP_STEP) d = RAMP_STEP;
            else if (d < -RAMP_STEP) d = -RAMP_STEP;
            new_pwm = m_pwm + d;
        end
        case (m_ph)
            P_IDLE:  if (m_tcmd != 0) begin m_ph = P_RUN; m_cmd = m_tcmd; end
            P_RUN:   if (m_tcmd != m_cmd) m_ph = P_BRAKE;
            P_BRAKE: if (m_pwm == 0) begin m_ph = P_DEAD; m_cmd = 0; m_dead = DEADTIME; end
            default: begin
                m_dead--;
                if (m_dead == 0) begin
                    if (m_tcmd == 0) m_ph = P_IDLE;
                    else begin m_ph = P_RUN; m_cmd = m_tcmd; end
                end
            end
        endcase
        m_pwm = new_pwm;
        if (wr) begin
            m_trip = 0;
            m_wd = WDOG;
            if (c > 4) begin m_tcmd = 0; m_tpwm = 0; m_bad = 1; end
            else begin m_tcmd = c; m_tpwm = (c == 0) ? 0 : p; m_bad = 0; end
        end else if (m_wd == 1) begin
            m_trip = 1; m_tcmd = 0; m_tpwm = 0; m_wd = 0;
        end else if (m_wd > 0) begin
            m_wd--;
        end
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising edge, return at the next falling edge
    task automatic step(input bit wr, input int c, input int p);
        cmd_wr = wr;
        cmd_in = 8'(c);
        pwm_in = 16'(p);
        @(posedge user_clk);
        model_edge(wr, c, p);
        @(negedge user_clk);
        cmd_wr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge user_clk);
        n_cmp++;
        if (act_vec !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs actual=%h required=%h", act_vec, 27'd0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 2000; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
        end
        n_cmp++;
        if (wdog_trip !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_trip actual=%b required=0", wdog_trip);
        end
    endtask

    task automatic test_ramp();
        int seen[$];
        int last;
        bit ok;
        bit early_idle;
        step(1, 1, 1024);
        step(0, 0, 0);
        n_cmp++;
        if (cmd_out !== 8'd1) begin
            n_fail++;
            $display("FAIL ramp_cmd_out actual=%0d required=1", cmd_out);
        end
        last = 0;
        early_idle = 0;
        for (int i = 0; i < 40 && pwm_out != 16'd1024; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL ramp_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
            if (int'(pwm_out) != last) begin seen.push_back(int'(pwm_out)); last = int'(pwm_out); end
            if (pwm_out != 16'd1024 && !busy) early_idle = 1;
        end
        ok = (seen.size() == 4);
        for (int k = 0; k < seen.size() && ok; k++) if (seen[k] != 256 * (k + 1)) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ramp_sequence actual_len=%0d last=%0d required=256,512,768,1024", seen.size(), last);
        end
        n_cmp++;
        if (busy !== 1'b0 || early_idle) begin
            n_fail++;
            $display("FAIL ramp_busy actual_final=%b dropped_early=%b required_final=0 dropped_early=0", busy, early_idle);
        end
    endtask

    task automatic test_reverse();
        int zero_cnt;
        int prev;
        bit rose;
        bit done;
        zero_cnt = 0; rose = 0; done = 0; prev = int'(pwm_out);
        step(1, 2, 512);
        for (int i = 0; i < 200 && !done; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reverse_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
            if (cmd_out == 8'd0) zero_cnt++;
            if (cmd_out == 8'd1 && int'(pwm_out) > prev) rose = 1;
            prev = int'(pwm_out);
            done = (cmd_out == 8'd2 && pwm_out == 16'd512 && !busy);
        end
        n_cmp++;
        if (zero_cnt != DEADTIME || !done || rose) begin
            n_fail++;
            $display("FAIL reverse_dead actual_stop_cycles=%0d settled=%b rose=%b required=%0d,1,0", zero_cnt, done, rose, DEADTIME);
        end
    endtask

    task automatic test_rewrite();
        int seen[$];
        int last;
        bit left_fwd;
        step(1, 0, 0);
        for (int i = 0; i < 200 && (cmd_out != 8'd0 || busy); i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rewrite_stop_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
        end
        step(1, 1, 300);
        last = 0;
        for (int i = 0; i < 40 && pwm_out != 16'd300; i++) begin
            step(0, 0, 0);
            if (int'(pwm_out) != last) begin seen.push_back(int'(pwm_out)); last = int'(pwm_out); end
        end
        n_cmp++;
        if (seen.size() != 2 || seen[0] != 256 || last != 300) begin
            n_fail++;
            $display("FAIL rewrite_up_seq actual_len=%0d last=%0d required=256,300", seen.size(), last);
        end
        seen.delete();
        left_fwd = 0;
        step(1, 1, 100);
        for (int i = 0; i < 40 && pwm_out != 16'd100; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rewrite_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
            if (cmd_out != 8'd1) left_fwd = 1;
            if (int'(pwm_out) != last) begin seen.push_back(int'(pwm_out)); last = int'(pwm_out); end
        end
        n_cmp++;
        if (seen.size() != 1 || last != 100 || left_fwd) begin
            n_fail++;
            $display("FAIL rewrite_down actual_len=%0d last=%0d left_fwd=%b required=1,100,0", seen.size(), last, left_fwd);
        end
    endtask

    task automatic test_watchdog();
        int n;
        step(1, 1, 1000);
        n = 0;
        while (!wdog_trip && n < 1100) begin
            step(0, 0, 0);
            n++;
        end
        n_cmp++;
        if (n != WDOG) begin
            n_fail++;
            $display("FAIL wdog_expiry_cycle actual=%0d required=%0d", n, WDOG);
        end
        for (int i = 0; i < 300 && (cmd_out != 8'd0 || busy); i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL wdog_brake_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
        end
        n_cmp++;
        if (pwm_out !== 16'd0 || cmd_out !== 8'd0 || wdog_trip !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_idle actual pwm=%0d cmd=%0d trip=%b required 0,0,1", pwm_out, cmd_out, wdog_trip);
        end
        step(1, 1, 500);
        n_cmp++;
        if (wdog_trip !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_clear actual=%b required=0", wdog_trip);
        end
        for (int i = 0; i < WDOG - 1; i++) step(0, 0, 0);
        step(1, 1, 500);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec() || wdog_trip !== 1'b0) begin
                n_fail++;
                $display("FAIL wdog_same_cycle_write t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_bad_cmd();
        step(1, 9, 777);
        n_cmp++;
        if (bad_cmd !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_cmd_set actual=%b required=1", bad_cmd);
        end
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL bad_cmd_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
        end
        n_cmp++;
        if (cmd_out !== 8'd0 || pwm_out !== 16'd0) begin
            n_fail++;
            $display("FAIL bad_cmd_stop actual cmd=%0d pwm=%0d required 0,0", cmd_out, pwm_out);
        end
        step(1, 3, 200);
        n_cmp++;
        if (bad_cmd !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_cmd_clear actual=%b required=0", bad_cmd);
        end
    endtask

    task automatic test_async_reset();
        step(1, 1, 2000);
        for (int i = 0; i < 80 && pwm_out < 16'd1024; i++) step(0, 0, 0);
        step(1, 2, 100);
        step(0, 0, 0);
        step(0, 0, 0);
        n_cmp++;
        if (act_vec !== exp_vec() || cmd_out !== 8'd1 || pwm_out === 16'd0) begin
            n_fail++;
            $display("FAIL async_pre_brake actual=%h required=%h", act_vec, exp_vec());
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act_vec !== 27'd0) begin
            n_fail++;
            $display("FAIL async_reset actual=%h required=%h", act_vec, 27'd0);
        end
        @(negedge user_clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL async_post_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int gap, c, p;
        for (int op = 0; op < 150; op++) begin
            c = int'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) c = int'($urandom_range(6, 255));
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 600)) : int'($urandom_range(0, 65535));
            step(1, c, p);
            n_cmp++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_write t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
            end
            gap = ($urandom_range(0, 12) == 0) ? 1100 : int'($urandom_range(0, 60));
            for (int i = 0; i < gap; i++) begin
                step(0, 0, 0);
                n_cmp++;
                if (act_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random_lockstep t=%0t actual=%h required=%h", $time, act_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_ramp();
        test_reverse();
        test_rewrite();
        test_watchdog();
        test_bad_cmd();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
